spi_reg_file_sync: RTL

Clock-domain-safe SPI target and control-register file feeding the PWM stage. It sits upstream of the PWM peripheral. Raw SCLK/COPI/nCS pins are oversampled in the system clock domain. 16-bit SPI mode-0 frames are decoded, and five 8-bit control registers (output enables, PWM enables, duty cycle) are written or read back. Every register update is synchronous to clk, so the PWM stage never sees a torn value.

---
 rtl/spi_reg_pkg.sv | 40 ++++
 rtl/spi_input_sync.sv | 48 ++++
 rtl/spi_reg_file_sync.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI target / control-register file:
//   - FSM state encoding
//   - frame geometry (frame length, R/W bit, address and data fields)
//   - register address map
//   - address range helper
// No ports (package).
// -----------------------------------------------------------------------------
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Frame geometry: [15] R/W (1 = write), [14:8] address, [7:0] data
  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 8;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;

  // Number of register output ports on the block
  localparam int REG_SLOTS = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int                num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// -----------------------------------------------------------------------------
// spi_input_sync
// Multi-flop synchroniser for one raw SPI pin, plus one extra flop holding the
// previous synchronised value so single-cycle rise/fall flags can be derived.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset (all flops load RST_VAL)
//   d_i     raw asynchronous input
//   q_o     synchronised value
//   prev_o  synchronised value delayed by one clk
//   rise_o  one-cycle flag: synchronised 0 -> 1
//   fall_o  one-cycle flag: synchronised 1 -> 0
// -----------------------------------------------------------------------------
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign prev_o = prev_q;
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_file_sync.sv
// -----------------------------------------------------------------------------
// spi_reg_file_sync
// SPI mode-0 target with a small control-register file for the PWM stage.
// Raw SCLK/COPI/nCS are oversampled in the clk domain; 16-bit frames write or
// read back one of the 8-bit registers. All register updates happen on clk.
//
// State table
//   state   | meaning
//   IDLE    | waiting for cs_n to fall
//   RECV    | shifting in frame bits, driving read data on cipo
//   HOLD    | frame is unusable (overrun or joined mid-frame); wait for cs_n
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   sclk_i, copi_i   raw SPI clock and controller-out data
//   cs_n_i           raw active-low chip select
//   cipo_o           target-out read data
//   cipo_oe_o        high while cipo_o carries read data
//   reg_0_o..reg_4_o output enables lo/hi, PWM enables lo/hi, duty cycle
//   wr_strobe_o      one-cycle pulse, aligned with the updated register value
//   frame_err_o      one-cycle pulse when a frame is discarded
// -----------------------------------------------------------------------------
module spi_reg_file_sync
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       cs_n_i,
  output logic       cipo_o,
  output logic       cipo_oe_o,
  output logic [7:0] reg_0_o,
  output logic [7:0] reg_1_o,
  output logic [7:0] reg_2_o,
  output logic [7:0] reg_3_o,
  output logic [7:0] reg_4_o,
  output logic       wr_strobe_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(FRAME_BITS - DATA_BITS);

  // After reset the synchronisers hold their reset values, not the pins.
  // Edge flags are ignored until the chain (plus the edge flop) has been
  // refilled from the pins; only then is the real cs_n level judged.
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(1);

  // Synchronised pins
  logic sclk_q, sclk_prev, sclk_rise, sclk_fall;
  logic copi_q, copi_prev, copi_rise, copi_fall;
  logic cs_q, cs_prev, cs_rise, cs_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_i),
    .q_o    (sclk_q),
    .prev_o (sclk_prev),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (copi_i),
    .q_o    (copi_q),
    .prev_o (copi_prev),
    .rise_o (copi_rise),
    .fall_o (copi_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs_n_i),
    .q_o    (cs_q),
    .prev_o (cs_prev),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, sclk_prev, copi_prev, copi_rise, copi_fall, cs_prev};

  // State
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [7:0]              tx_q, tx_d;
  logic                    cipo_oe_q, cipo_oe_d;
  logic [7:0]              regs_q [REG_SLOTS];
  logic [7:0]              regs_d [REG_SLOTS];
  logic                    wr_strobe_q, wr_strobe_d;
  logic                    frame_err_q, frame_err_d;
  logic [FLUSH_W-1:0]      flush_q, flush_d;
  // HOLD entered straight out of reset: the closing cs_n rise is not an error
  logic                    quiet_q, quiet_d;

  // Header fields as they sit in rx after 8 bits, and full-frame fields
  logic                    hdr_rw;
  logic [ADDR_W-1:0]       hdr_addr;
  logic                    frm_rw;
  logic [ADDR_W-1:0]       frm_addr;
  logic [DATA_BITS-1:0]    frm_data;
  logic [7:0]              rd_data;

  assign hdr_rw   = rx_q[RW_BIT - DATA_BITS];
  assign hdr_addr = rx_q[ADDR_MSB - DATA_BITS : ADDR_LSB - DATA_BITS];
  assign frm_rw   = rx_q[RW_BIT];
  assign frm_addr = rx_q[ADDR_MSB:ADDR_LSB];
  assign frm_data = rx_q[DATA_BITS-1:0];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      flush_q     <= FLUSH_INIT;
      quiet_q     <= 1'b0;
      for (int i = 0; i < REG_SLOTS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      flush_q     <= flush_d;
      quiet_q     <= quiet_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    cipo_oe_d   = cipo_oe_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    flush_d     = flush_q;
    quiet_d     = quiet_q;
    regs_d      = regs_q;

    if (flush_q != '0) begin
      flush_d = flush_q - FLUSH_W'(1);
      // cs_n already low when we come out of reset: sit out this frame
      if (flush_q == FLUSH_LAST && !cs_q) begin
        state_d = ST_HOLD;
        quiet_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_RECV;
            bit_cnt_d = '0;
            rx_d      = '0;
          end
        end

        ST_RECV: begin
          if (cs_rise) begin
            state_d   = ST_IDLE;
            tx_d      = '0;
            cipo_oe_d = 1'b0;
            if (bit_cnt_q != CNT_FULL) begin
              frame_err_d = 1'b1;
            end else if (frm_rw) begin
              if (addr_in_range(frm_addr, NUM_REGS)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (frm_addr == ADDR_W'(i)) regs_d[i] = frm_data;
                end
                wr_strobe_d = 1'b1;
              end else begin
                frame_err_d = 1'b1;
              end
            end
          end else if (sclk_rise) begin
            rx_d = {rx_q[FRAME_BITS-2:0], copi_q};
            if (bit_cnt_q == CNT_FULL) begin
              bit_cnt_d = CNT_OVR;
              state_d   = ST_HOLD;
              quiet_d   = 1'b0;
              tx_d      = '0;
              cipo_oe_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            // Header complete: present the addressed register MSB first
            if (bit_cnt_q == CNT_HDR && !hdr_rw && addr_in_range(hdr_addr, NUM_REGS)) begin
              tx_d      = rd_data;
              cipo_oe_d = 1'b1;
            end else if (cipo_oe_q) begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end

        ST_HOLD: begin
          if (cs_rise) begin
            state_d     = ST_IDLE;
            frame_err_d = ~quiet_q;
            quiet_d     = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cipo_o      = tx_q[7];
  assign cipo_oe_o   = cipo_oe_q;
  assign wr_strobe_o = wr_strobe_q;
  assign frame_err_o = frame_err_q;

  assign reg_0_o = regs_q[ADDR_EN_OUT_LO];
  assign reg_1_o = regs_q[ADDR_EN_OUT_HI];
  assign reg_2_o = regs_q[ADDR_EN_PWM_LO];
  assign reg_3_o = regs_q[ADDR_EN_PWM_HI];
  assign reg_4_o = regs_q[ADDR_DUTY];

endmodule
